// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the writeback pipeline always wins, while
// mul/div results wait in a 2-entry FIFO and drain on idle write-port cycles.
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        MdValid,
    input  logic [4:0]  MdReg,
    input  logic [31:0] MdData,
    output logic        MdReady,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    output logic        PendingHit,
    output logic        StarveStall,
    output logic        RFWE,
    output logic [4:0]  RFWA,
    output logic [31:0] RFWD
);

    logic [4:0]  regMem  [2];
    logic [31:0] dataMem [2];

    logic [1:0] countReg, countNext;
    logic       rdPtrReg, rdPtrNext;
    logic       wrPtrReg, wrPtrNext;
    logic [2:0] starveCntReg, starveCntNext;
    logic       starveStallReg, starveStallNext;

    logic       pipeWrite;
    logic       drain;
    logic       enq;
    logic       pop;
    logic [1:0] entryValid;
    logic [1:0] entryHit;
    logic [1:0] entryDrop;
    logic [4:0] entryReg [2];

    assign pipeWrite = RegWriteW && (WriteRegW != 5'd0);
    assign MdReady   = (countReg < 2'd2);
    assign drain     = !pipeWrite && (countReg != 2'd0);
    // Zero-register offers are swallowed; offers overwritten by a same-cycle pipeline write are stale.
    assign enq       = MdValid && MdReady && (MdReg != 5'd0)
                       && !(pipeWrite && (MdReg == WriteRegW));

    // Entry 0 is the head, entry 1 the one behind it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gEntry
            assign entryValid[gi] = (countReg > 2'(gi));
            assign entryReg[gi]   = regMem[rdPtrReg ^ 1'(gi)];
            assign entryHit[gi]   = entryValid[gi] && (entryReg[gi] != 5'd0)
                                    && ((entryReg[gi] == RsD) || (entryReg[gi] == RtD));
            assign entryDrop[gi]  = pipeWrite && entryValid[gi] && (entryReg[gi] == WriteRegW);
        end
    endgenerate

    assign PendingHit  = |entryHit;
    assign StarveStall = starveStallReg;

    always_comb begin
        RFWE = 1'b0;
        RFWA = 5'd0;
        RFWD = 32'd0;
        if (pipeWrite) begin
            RFWE = 1'b1;
            RFWA = WriteRegW;
            RFWD = ResultW;
        end else if (drain) begin
            RFWE = 1'b1;
            RFWA = entryReg[0];
            RFWD = dataMem[rdPtrReg];
        end
    end

    // A dropped tail only exists when full, so it never coincides with an enqueue.
    always_comb begin
        pop             = drain || entryDrop[0];
        countNext       = countReg - 2'(pop) - 2'(entryDrop[1]) + 2'(enq);
        rdPtrNext       = rdPtrReg ^ pop;
        wrPtrNext       = wrPtrReg ^ entryDrop[1] ^ enq;
        starveCntNext   = 3'd0;
        starveStallNext = 1'b0;
        if ((countReg != 2'd0) && !drain) begin
            starveCntNext   = (starveCntReg == 3'd7) ? 3'd7 : starveCntReg + 3'd1;
            starveStallNext = (starveCntNext == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg       <= 2'd0;
            rdPtrReg       <= 1'b0;
            wrPtrReg       <= 1'b0;
            starveCntReg   <= 3'd0;
            starveStallReg <= 1'b0;
        end else begin
            countReg       <= countNext;
            rdPtrReg       <= rdPtrNext;
            wrPtrReg       <= wrPtrNext;
            starveCntReg   <= starveCntNext;
            starveStallReg <= starveStallNext;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            regMem[wrPtrReg]  <= MdReg;
            dataMem[wrPtrReg] <= MdData;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed check of wb_port_arbiter against a queue-based model
// of write-port priority, WAW drops and starvation.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RegWriteW = 1'b0;
    logic [4:0]  WriteRegW = '0;
    logic [31:0] ResultW = '0;
    logic        MdValid = 1'b0;
    logic [4:0]  MdReg = '0;
    logic [31:0] MdData = '0;
    logic        MdReady;
    logic [4:0]  RsD = '0;
    logic [4:0]  RtD = '0;
    logic        PendingHit;
    logic        StarveStall;
    logic        RFWE;
    logic [4:0]  RFWA;
    logic [31:0] RFWD;

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .MdValid(MdValid), .MdReg(MdReg), .MdData(MdData), .MdReady(MdReady),
        .RsD(RsD), .RtD(RtD), .PendingHit(PendingHit), .StarveStall(StarveStall),
        .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t q[$];
    int     starveRun = 0;
    bit     stallExp = 1'b0;
    int     assertCount = 0;
    int     failCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        starveRun = 0;
        stallExp  = 1'b0;
    endtask

    // One clock cycle: drive after the falling edge, check the settled outputs,
    // then advance the model across the rising edge.
    task automatic doCycle(input bit rw, input logic [4:0] wr, input logic [31:0] res,
                           input bit mv, input logic [4:0] mr, input logic [31:0] md,
                           input logic [4:0] rs, input logic [4:0] rt);
        bit          pipe, hit, popped, accept;
        logic        expWe;
        logic [4:0]  expWa;
        logic [31:0] expWd;
        int          sizeBefore;
        @(negedge clk);
        RegWriteW = rw; WriteRegW = wr; ResultW = res;
        MdValid = mv; MdReg = mr; MdData = md; RsD = rs; RtD = rt;
        #1;
        pipe = rw && (wr != 0);
        sizeBefore = q.size();
        hit = 1'b0;
        foreach (q[i]) if (q[i].r == rs || q[i].r == rt) hit = 1'b1;
        expWe = 1'b0; expWa = '0; expWd = '0;
        if (pipe) begin
            expWe = 1'b1; expWa = wr; expWd = res;
        end else if (sizeBefore > 0) begin
            expWe = 1'b1; expWa = q[0].r; expWd = q[0].d;
        end
        checkVal("MdReady", 32'(MdReady), 32'(sizeBefore < 2));
        checkVal("PendingHit", 32'(PendingHit), 32'(hit));
        checkVal("StarveStall", 32'(StarveStall), 32'(stallExp));
        checkVal("RFWE", 32'(RFWE), 32'(expWe));
        checkVal("RFWA", 32'(RFWA), 32'(expWa));
        checkVal("RFWD", RFWD, expWd);
        $display("cyc rw=%0d wr=%0d mv=%0d mr=%0d q=%0d -> we=%0d wa=%0d wd=%08h rdy=%0d hit=%0d stall=%0d",
                 rw, wr, mv, mr, sizeBefore, RFWE, RFWA, RFWD, MdReady, PendingHit, StarveStall);
        @(posedge clk);
        popped = 1'b0;
        if (pipe) begin
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].r == wr) q.delete(i);
        end else if (sizeBefore > 0) begin
            void'(q.pop_front());
            popped = 1'b1;
        end
        accept = mv && (sizeBefore < 2) && (mr != 0) && !(pipe && mr == wr);
        if (accept) q.push_back('{r: mr, d: md});
        if (sizeBefore == 0 || popped) starveRun = 0;
        else if (starveRun < 7) starveRun++;
        stallExp = (starveRun == 7);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) doCycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Pulse rst_n low between clock edges and check the asynchronous response.
    task automatic pulseReset();
        @(negedge clk);
        RegWriteW = 1'b0; MdValid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkVal("rst MdReady", 32'(MdReady), 32'd1);
        checkVal("rst RFWE", 32'(RFWE), 32'd0);
        checkVal("rst PendingHit", 32'(PendingHit), 32'(0));
        checkVal("rst StarveStall", 32'(StarveStall), 32'd0);
        $display("reset pulse: rdy=%0d we=%0d hit=%0d stall=%0d", MdReady, RFWE, PendingHit, StarveStall);
        modelReset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2;
        checkVal("init MdReady", 32'(MdReady), 32'd1);
        checkVal("init RFWE", 32'(RFWE), 32'd0);
        checkVal("init StarveStall", 32'(StarveStall), 32'd0);
        #1 rst_n = 1'b1;

        // single offer drains one cycle later
        doCycle(0, 0, 0, 1, 5, 32'h12345678, 0, 0);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // two offers starved behind a continuous pipeline write to reg 9
        doCycle(1, 9, 32'hAAAA0001, 1, 3, 32'h33333333, 0, 0);
        doCycle(1, 9, 32'hAAAA0002, 1, 4, 32'h44444444, 0, 0);
        for (int i = 0; i < 9; i++) doCycle(1, 9, 32'hAAAA0100 + i, 1, 11, 32'hBBBB0000, 3, 0);
        checkVal("starve stall", 32'(StarveStall), 32'd1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // WAW drop of a queued entry
        doCycle(1, 9, 32'h1, 1, 7, 32'h77777777, 0, 0);
        doCycle(1, 7, 32'h70707070, 0, 0, 0, 7, 0);
        idle(2);

        // PendingHit follows an entry until it is written
        doCycle(1, 2, 32'h2, 1, 8, 32'h88888888, 8, 0);
        doCycle(1, 2, 32'h2, 0, 0, 0, 8, 0);
        doCycle(0, 0, 0, 0, 0, 0, 8, 0);
        doCycle(0, 0, 0, 0, 0, 0, 8, 0);

        // full FIFO with a dequeue and an offer in the same cycle
        doCycle(1, 1, 32'h1, 1, 12, 32'hC0C0C0C0, 0, 0);
        doCycle(1, 1, 32'h1, 1, 13, 32'hD0D0D0D0, 0, 0);
        doCycle(0, 0, 0, 1, 14, 32'hE0E0E0E0, 0, 0);
        doCycle(1, 1, 32'h1, 1, 14, 32'hE0E0E0E0, 0, 0);
        doCycle(1, 1, 32'h1, 0, 0, 0, 0, 0);
        checkVal("count two", 32'(MdReady), 32'd0);

        // suppressed write to reg 0 lets the drain proceed
        doCycle(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);

        // reset with two entries queued; nothing may be written afterwards
        doCycle(1, 1, 32'h1, 1, 15, 32'hF0F0F0F0, 0, 0);
        pulseReset();
        idle(3);

        // randomized traffic with a small register set to force collisions
        for (int n = 0; n < 600; n++) begin
            bit          rw, mv;
            logic [4:0]  wr, mr, rs, rt;
            rw = ($urandom_range(0, 9) < 5);
            wr = 5'($urandom_range(0, 6));
            mv = ($urandom_range(0, 9) < 6);
            mr = 5'($urandom_range(0, 6));
            rs = 5'($urandom_range(0, 6));
            rt = 5'($urandom_range(0, 6));
            if ($urandom_range(0, 99) == 0) pulseReset();
            doCycle(rw, wr, $urandom, mv, mr, $urandom, rs, rt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
